// File: rtl/uart_tx_scheduler_if.sv
// Sample-stream and UART-TX side signals of the scope capture-and-dump controller.
// master drives samples/arm and observes the TX side; slave is the scheduler itself.
interface uart_tx_scheduler_if;
    logic       arm;
    logic       force_trig;
    logic       sample_valid;
    logic [7:0] sample;
    logic [7:0] trig_level;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       frame_done;
    logic [2:0] state;

    modport master (
        output arm, force_trig, sample_valid, sample, trig_level,
        input  tx_data, tx_start, busy, frame_done, state
    );

    modport slave (
        input  arm, force_trig, sample_valid, sample, trig_level,
        output tx_data, tx_start, busy, frame_done, state
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Arm, wait for a rising threshold crossing, capture DEPTH samples, then pace sync + data bytes to a UART TX.
// Optional trailing two's-complement checksum byte is enabled by defining TXSCHED_CHECKSUM_EN.
module uart_tx_scheduler #(
    parameter int         DELAY_FRAMES = 234,
    parameter int         GAP_FRAMES   = 4,
    parameter int         DEPTH        = 256,
    parameter int         ADDR_W       = 8,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_scheduler_if.slave bus
);
    localparam int                BYTE_SLOT = 10 * DELAY_FRAMES + GAP_FRAMES;
    localparam int                SLOT_W    = $clog2(BYTE_SLOT);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(BYTE_SLOT - 1);
    localparam logic [ADDR_W-1:0] WPTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   RPTR_END  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARMED     = 3'd1,
        S_CAPTURE   = 3'd2,
        S_SEND_SYNC = 3'd3,
        S_SEND_DATA = 3'd4,
        S_SEND_SUM  = 3'd5
    } state_t;

    state_t            r_state, w_state_next;
    logic [7:0]        r_buf [DEPTH];
    logic [7:0]        r_rd_data;
    logic [7:0]        r_thr, r_prev, r_tx_data;
    logic              r_prev_valid, r_tx_start, r_frame_done;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W:0]   r_rptr;
    logic [SLOT_W-1:0] r_slot;
`ifdef TXSCHED_CHECKSUM_EN
    logic [7:0]        r_sum;
`endif

    logic              w_trig, w_wr_en, w_in_send, w_slot_last, w_slot_start, w_frame_end;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [7:0]        w_next_byte;

    always_comb begin
        w_state_next = r_state;
        w_trig       = bus.force_trig || (r_prev_valid && (r_prev < r_thr) && (bus.sample >= r_thr));
        w_in_send    = r_state inside {S_SEND_SYNC, S_SEND_DATA, S_SEND_SUM};
        w_slot_last  = w_in_send && (r_slot == SLOT_LAST);
        w_wr_en      = 1'b0;
        w_wr_addr    = r_wptr;
        w_next_byte  = r_rd_data;
        case (r_state)
            S_IDLE:    if (bus.arm) w_state_next = S_ARMED;
            S_ARMED:   if (bus.sample_valid && w_trig) begin
                w_state_next = S_CAPTURE;
                w_wr_en      = 1'b1;
                w_wr_addr    = '0;
            end
            S_CAPTURE: if (bus.sample_valid) begin
                w_wr_en = 1'b1;
                if (r_wptr == WPTR_LAST) begin
                    w_state_next = S_SEND_SYNC;
                    w_next_byte  = SYNC_BYTE;
                end
            end
            S_SEND_SYNC: if (w_slot_last) w_state_next = S_SEND_DATA;
            S_SEND_DATA: if (w_slot_last && (r_rptr == RPTR_END)) begin
`ifdef TXSCHED_CHECKSUM_EN
                w_state_next = S_SEND_SUM;
                w_next_byte  = 8'h00 - r_sum;
`else
                w_state_next = S_IDLE;
`endif
            end
            S_SEND_SUM:  if (w_slot_last) w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
        w_slot_start = ((r_state == S_CAPTURE) && (w_state_next == S_SEND_SYNC)) ||
                       (w_slot_last && (w_state_next != S_IDLE));
        w_frame_end  = w_slot_last && (w_state_next == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_thr        <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_slot       <= '0;
            r_tx_data    <= '0;
            r_tx_start   <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef TXSCHED_CHECKSUM_EN
            r_sum        <= '0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_tx_start   <= w_slot_start;
            r_frame_done <= w_frame_end;
            if (w_slot_start) r_tx_data <= w_next_byte;
            if (w_slot_start || w_frame_end) r_slot <= '0;
            else if (w_in_send)              r_slot <= r_slot + SLOT_W'(1);
            case (r_state)
                S_IDLE: if (bus.arm) begin
                    r_thr        <= bus.trig_level;
                    r_prev_valid <= 1'b0;
                end
                S_ARMED: if (bus.sample_valid) begin
                    if (w_trig) begin
                        r_wptr <= ADDR_W'(1);
                    end else begin
                        r_prev       <= bus.sample;
                        r_prev_valid <= 1'b1;
                    end
                end
                S_CAPTURE: if (bus.sample_valid) begin
                    r_wptr <= r_wptr + ADDR_W'(1);
                    if (r_wptr == WPTR_LAST) begin
                        r_rptr <= '0;
`ifdef TXSCHED_CHECKSUM_EN
                        r_sum  <= '0;
`endif
                    end
                end
                // r_rptr always names the byte of the next slot; r_rd_data holds its prefetched value
                S_SEND_SYNC, S_SEND_DATA: if (w_slot_last && (r_rptr != RPTR_END)) begin
                    r_rptr <= r_rptr + (ADDR_W + 1)'(1);
`ifdef TXSCHED_CHECKSUM_EN
                    r_sum  <= r_sum + r_rd_data;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_buf[w_wr_addr] <= bus.sample;
        r_rd_data <= r_buf[r_rptr[ADDR_W-1:0]];
    end

    assign bus.tx_data    = r_tx_data;
    assign bus.tx_start   = r_tx_start;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.frame_done = r_frame_done;
    assign bus.state      = r_state;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: random sample streams checked against a queue-based frame model.
// Frame length adapts to TXSCHED_CHECKSUM_EN.
module tb_uart_tx_scheduler;
    localparam int DF    = 4;
    localparam int GF    = 4;
    localparam int DEPTH = 8;
    localparam int SLOT  = 10 * DF + GF;
`ifdef TXSCHED_CHECKSUM_EN
    localparam int N_SLOTS = DEPTH + 2;
`else
    localparam int N_SLOTS = DEPTH + 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_scheduler_if bus();

    uart_tx_scheduler #(
        .DELAY_FRAMES(DF),
        .GAP_FRAMES  (GF),
        .DEPTH       (DEPTH),
        .ADDR_W      (3),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] obs_bytes[$];
    int         obs_start[$];
    int         done_cyc[$];
    int         stab_err = 0;
    logic [7:0] cur_byte = '0;
    logic [7:0] exp_bytes[$];
    logic [7:0] stim_q[$];
    logic [7:0] stim_thr;

    // Log every slot start; flag any tx_data change inside a slot.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.tx_start) begin
                obs_bytes.push_back(bus.tx_data);
                obs_start.push_back(cyc);
                cur_byte = bus.tx_data;
            end else if (bus.state >= 3'd3 && bus.tx_data !== cur_byte) begin
                stab_err++;
            end
            if (bus.frame_done) done_cyc.push_back(cyc);
        end
    end

    // Trigger = first valid sample at/after force_idx, or first rising crossing after the first sample.
    function automatic int model_frame(input logic [7:0] s[$], input logic [7:0] thr, input int force_idx);
        int t = -1;
        int sum = 0;
        exp_bytes = {8'hA5};
        for (int i = 0; i < s.size(); i++) begin
            if (i >= force_idx || (i > 0 && s[i-1] < thr && s[i] >= thr)) begin
                t = i;
                break;
            end
        end
        if (t < 0 || t + DEPTH > s.size()) return -1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_bytes.push_back(s[t+i]);
            sum += int'(s[t+i]);
        end
`ifdef TXSCHED_CHECKSUM_EN
        exp_bytes.push_back(8'((256 - sum % 256) % 256));
`endif
        return t;
    endfunction

    task automatic gen_stream(input int n);
        int t = -1;
        for (int k = 0; k < 100 && t < 0; k++) begin
            stim_q   = {};
            stim_thr = 8'($urandom_range(1, 255));
            for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
            t = model_frame(stim_q, stim_thr, n + 100);
        end
        if (t < 0) begin
            stim_q[0] = stim_thr - 8'd1;
            stim_q[1] = stim_thr;
            t = model_frame(stim_q, stim_thr, n + 100);
        end
    endtask

    task automatic clear_obs();
        obs_bytes = {};
        obs_start = {};
        done_cyc  = {};
        stab_err  = 0;
    endtask

    task automatic do_arm(input logic [7:0] thr);
        bus.arm        = 1'b1;
        bus.trig_level = thr;
        @(posedge clk); #1;
        bus.arm        = 1'b0;
        bus.trig_level = 8'($urandom);
    endtask

    task automatic drive_samples(input logic [7:0] s[$], input int gap, input int force_idx);
        for (int i = 0; i < s.size(); i++) begin
            bus.sample       = s[i];
            bus.sample_valid = 1'b1;
            bus.force_trig   = (i >= force_idx);
            @(posedge clk); #1;
            bus.sample_valid = 1'b0;
            bus.force_trig   = 1'b0;
            bus.sample       = 8'($urandom);
            for (int g = 1; g < gap; g++) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (done_cyc.size() > 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        bus.arm = 1'b0; bus.force_trig = 1'b0; bus.sample_valid = 1'b0;
        bus.sample = '0; bus.trig_level = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.state !== 3'd0)     begin n_fail++; $display("FAIL reset_state: got %0d want 0", bus.state); end
        n_checks++; if (bus.tx_start !== 1'b0)  begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", bus.tx_start); end
        n_checks++; if (bus.tx_data !== 8'h00)  begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
        n_checks++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", bus.frame_done); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_level_trigger();
        logic [7:0] s[$];
        bit ok;
        int t;
        clear_obs();
        s = {8'd10, 8'd20, 8'h7F, 8'h80, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        t = model_frame(s, 8'h80, 99);
        do_arm(8'h80);
        drive_samples(s, 1, 99);
        n_checks++; if (bus.state !== 3'd3 || bus.busy !== 1'b1 || bus.tx_start !== 1'b1)
            begin n_fail++; $display("FAIL level_sync_entry: state %0d busy %b start %b want 3 1 1", bus.state, bus.busy, bus.tx_start); end
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL level_timeout: frame_done not seen want pulse"); end
        n_checks++; if (obs_bytes.size() !== exp_bytes.size())
            begin n_fail++; $display("FAIL level_count: got %0d want %0d", obs_bytes.size(), exp_bytes.size()); end
        for (int i = 0; i < exp_bytes.size() && i < obs_bytes.size(); i++) begin
            n_checks++; if (obs_bytes[i] !== exp_bytes[i]) begin n_fail++; $display("FAIL level_byte%0d: got %h want %h", i, obs_bytes[i], exp_bytes[i]); end
        end
        for (int i = 1; i < obs_start.size(); i++) begin
            n_checks++; if (obs_start[i] - obs_start[i-1] !== SLOT)
                begin n_fail++; $display("FAIL level_spacing%0d: got %0d want %0d", i, obs_start[i] - obs_start[i-1], SLOT); end
        end
        if (done_cyc.size() > 0 && obs_start.size() > 0) begin
            n_checks++; if (done_cyc[0] - obs_start[0] !== N_SLOTS * SLOT)
                begin n_fail++; $display("FAIL level_done_time: got %0d want %0d", done_cyc[0] - obs_start[0], N_SLOTS * SLOT); end
        end
        n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL level_stability: got %0d changes want 0", stab_err); end
        n_checks++; if (bus.state !== 3'd0 || bus.busy !== 1'b0)
            begin n_fail++; $display("FAIL level_idle: state %0d busy %b want 0 0", bus.state, bus.busy); end
    endtask

    task automatic test_no_false_trigger();
        logic [7:0] pre[$];
        logic [7:0] rest[$];
        logic [7:0] all[$];
        bit ok;
        int t;
        clear_obs();
        pre = {8'h90, 8'h70, 8'h60};
        do_arm(8'h80);
        drive_samples(pre, 1, 99);
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL nofalse_state: got %0d want 1", bus.state); end
        n_checks++; if (obs_bytes.size() !== 0) begin n_fail++; $display("FAIL nofalse_tx: got %0d starts want 0", obs_bytes.size()); end
        for (int i = 0; i < DEPTH + 4; i++) rest.push_back(8'($urandom));
        all = {pre, rest};
        t = model_frame(all, 8'h80, 3);
        drive_samples(rest, 1, 0);
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL force_timeout: frame_done not seen want pulse"); end
        n_checks++; if (obs_bytes.size() !== exp_bytes.size())
            begin n_fail++; $display("FAIL force_count: got %0d want %0d", obs_bytes.size(), exp_bytes.size()); end
        for (int i = 0; i < exp_bytes.size() && i < obs_bytes.size(); i++) begin
            n_checks++; if (obs_bytes[i] !== exp_bytes[i]) begin n_fail++; $display("FAIL force_byte%0d: got %h want %h", i, obs_bytes[i], exp_bytes[i]); end
        end
    endtask

    task automatic test_gapped_random();
        bit ok;
        for (int r = 0; r < 3; r++) begin
            clear_obs();
            gen_stream(40);
            do_arm(stim_thr);
            drive_samples(stim_q, 3, 999);
            wait_done(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL gap%0d_timeout: frame_done not seen want pulse", r); end
            n_checks++; if (obs_bytes.size() !== exp_bytes.size())
                begin n_fail++; $display("FAIL gap%0d_count: got %0d want %0d", r, obs_bytes.size(), exp_bytes.size()); end
            for (int i = 0; i < exp_bytes.size() && i < obs_bytes.size(); i++) begin
                n_checks++; if (obs_bytes[i] !== exp_bytes[i]) begin n_fail++; $display("FAIL gap%0d_byte%0d: got %h want %h", r, i, obs_bytes[i], exp_bytes[i]); end
            end
            n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL gap%0d_stability: got %0d want 0", r, stab_err); end
        end
    endtask

    task automatic test_arm_during_busy();
        bit ok;
        int c;
        clear_obs();
        gen_stream(20);
        do_arm(stim_thr);
        drive_samples(stim_q, 1, 999);
        for (c = 0; c < 2000 && obs_bytes.size() < 3; c++) begin
            @(posedge clk); #1;
        end
        n_checks++; if (bus.state !== 3'd4) begin n_fail++; $display("FAIL busyarm_state: got %0d want 4", bus.state); end
        do_arm(8'h00);
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL busyarm_timeout: frame_done not seen want pulse"); end
        for (int i = 0; i < exp_bytes.size() && i < obs_bytes.size(); i++) begin
            n_checks++; if (obs_bytes[i] !== exp_bytes[i]) begin n_fail++; $display("FAIL busyarm_byte%0d: got %h want %h", i, obs_bytes[i], exp_bytes[i]); end
        end
        bus.force_trig = 1'b1;
        bus.sample_valid = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        bus.force_trig = 1'b0;
        bus.sample_valid = 1'b0;
        n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL busyarm_idle: got %0d want 0", bus.state); end
        n_checks++; if (obs_bytes.size() !== exp_bytes.size())
            begin n_fail++; $display("FAIL busyarm_count: got %0d want %0d", obs_bytes.size(), exp_bytes.size()); end
    endtask

    task automatic test_async_reset();
        bit ok;
        int seen = 0;
        clear_obs();
        gen_stream(20);
        do_arm(stim_thr);
        drive_samples(stim_q, 1, 999);
        for (int c = 0; c < 2000 && seen < 4; c++) begin
            if (bus.tx_start) seen++;
            if (seen < 4) begin @(posedge clk); #1; end
        end
        n_checks++; if (seen !== 4) begin n_fail++; $display("FAIL rst_slot3_timeout: got %0d starts want 4", seen); end
        repeat (19) @(posedge clk);
        #2;
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy: got %b want 1", bus.busy); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.state !== 3'd0)    begin n_fail++; $display("FAIL rst_mid_state: got %0d want 0", bus.state); end
        n_checks++; if (bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tx_start: got %b want 0", bus.tx_start); end
        n_checks++; if (bus.busy !== 1'b0)     begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_tx_data: got %h want 00", bus.tx_data); end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        clear_obs();
        gen_stream(20);
        do_arm(stim_thr);
        drive_samples(stim_q, 1, 999);
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_new_timeout: frame_done not seen want pulse"); end
        n_checks++; if (obs_bytes.size() !== exp_bytes.size())
            begin n_fail++; $display("FAIL rst_new_count: got %0d want %0d", obs_bytes.size(), exp_bytes.size()); end
        for (int i = 0; i < exp_bytes.size() && i < obs_bytes.size(); i++) begin
            n_checks++; if (obs_bytes[i] !== exp_bytes[i]) begin n_fail++; $display("FAIL rst_new_byte%0d: got %h want %h", i, obs_bytes[i], exp_bytes[i]); end
        end
        n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL rst_new_stability: got %0d want 0", stab_err); end
    endtask

    initial begin
        test_reset();
        test_level_trigger();
        test_no_false_trigger();
        test_gapped_random();
        test_arm_during_busy();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Scope capture-and-dump controller sitting between the ADC sample stream and the UART TX block.
- After being armed, waits for a rising-edge trigger on the sample stream and captures DEPTH samples into an internal buffer.
- Then sequences the frame to the UART TX: sync byte, DEPTH data bytes, optional checksum.
- The UART TX has no busy/ack output, so this block owns byte pacing. It drives the TX data byte and a one-cycle start pulse, then holds each byte for one full byte slot.

Parameters:
- DELAY_FRAMES, 234: clocks per UART bit. Must match the UART TX instance (27 MHz / 115200).
- GAP_FRAMES, 4: idle guard clocks appended to each byte slot.
- DEPTH, 256: samples per capture. Power of two, 2..1024.
- ADDR_W, 8: log2(DEPTH).
- SYNC_BYTE, 8'hA5: first byte of every frame.

Ports:
- clk  in  1  system clock (27 MHz)
- rst  in  1  asynchronous reset, active-high
- arm  in  1  one-cycle request to start a capture; honoured only in IDLE
- force_trig  in  1  level; when high in ARMED, triggers on the next valid sample regardless of level
- sample_valid  in  1  qualifies sample for one cycle
- sample  in  8  ADC code
- trig_level  in  8  trigger threshold; sampled when arm is accepted
- tx_data  out  8  byte for UART TX dataOut
- tx_start  out  1  one-cycle pulse to UART TX readyToTransmit
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at end of last byte slot
- state  out  3  current state encoding, for LEDs/debug

Behaviour:
- Reset (async, any time, including mid-capture or mid-byte):
  - state=IDLE; tx_start=0; tx_data=8'h00; busy=0; frame_done=0.
  - Write pointer, byte counter, slot counter and checksum all cleared.
  - Buffer contents are not reset.
- Encodings: IDLE=0, ARMED=1, CAPTURE=2, SEND_SYNC=3, SEND_DATA=4, SEND_SUM=5.
- IDLE:
  - arm=1 → latch trig_level into thr, clear prev_valid, go to ARMED next cycle.
  - Samples are ignored.
- ARMED: on each sample_valid, trigger if either of these holds:
  - force_trig=1; or
  - prev_valid=1, prev<thr and sample>=thr (unsigned compare).
  - On trigger: write sample to buf[0], set wptr=1, go to CAPTURE.
  - Otherwise: prev<=sample, prev_valid<=1.
  - The first valid sample after arm can trigger only via force_trig.
- CAPTURE:
  - Each sample_valid writes buf[wptr] and increments wptr.
  - The write at wptr=DEPTH-1 goes to SEND_SYNC next cycle, with the slot counter cleared.
  - No wrap; samples after the last write are dropped.
- Byte slot, common to all SEND_* states:
  - Slot length BYTE_SLOT = 10*DELAY_FRAMES + GAP_FRAMES clocks. The slot counter is sized to hold BYTE_SLOT-1.
  - In a slot's first cycle, tx_data is loaded and tx_start=1 for exactly that one cycle.
  - tx_data holds stable for the entire slot.
  - The state's advance decision is made in the slot's last cycle (counter = BYTE_SLOT-1). The next slot starts the following cycle.
- SEND_SYNC: one slot with tx_data=SYNC_BYTE, then SEND_DATA with rptr=0.
- SEND_DATA:
  - One slot per byte; tx_data=buf[rptr]. Registered buffer read; first-cycle latency is hidden by prefetching during the previous slot.
  - After the slot with rptr=DEPTH-1 → SEND_SUM if the feature is enabled, else IDLE.
  - The transition to IDLE pulses frame_done.
- arm while busy: ignored, not queued.
- sample_valid in SEND_*: ignored.
- trig_level changes after arm: no effect until the next arm.
- Full frame duration: (DEPTH+1[+1]) * BYTE_SLOT clocks from entering SEND_SYNC.

Optional Feature:
- Macro: TXSCHED_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum, modulo 256, of the DEPTH data bytes, cleared on entering SEND_SYNC.
  - SEND_SUM sends one extra slot with tx_data = two's complement of the sum, so that sum of data + checksum = 0.
  - Then IDLE and frame_done.
- Undefined:
  - SEND_SUM is unreachable and the state encoding is unused.
  - Frame is sync + DEPTH bytes.

Test Plan (DELAY_FRAMES=4, GAP_FRAMES=4 → BYTE_SLOT=44; DEPTH=8, ADDR_W=3):
- Level trigger: arm with trig_level=8'h80; sample_valid every cycle with 10,20,0x7F,0x80,1,2,3,4,5,6,7 → trigger on 0x80. buf = 80,01,02,03,04,05,06,07. Then tx_start pulses with A5 then those 8 bytes, 44 cycles apart; frame_done exactly 9*44 clocks after the first tx_start (10*44 with checksum). Checksum byte = 0x100-0x9C = 0x64.
- No trigger on first sample / no falling trigger: arm, then 0x90,0x70,0x60 with threshold 0x80 → stays ARMED, tx_start never asserts. Assert force_trig → next sample triggers and captures.
- Gapped sample_valid: sample_valid every 3rd cycle through capture → exactly 8 writes, in order. Samples during SEND_* do not alter transmitted bytes.
- arm during busy: pulse arm mid SEND_DATA → frame completes unchanged, state returns to IDLE (0), no new capture starts.
- Async reset mid-byte: assert rst in the 20th cycle of slot 3 → the same cycle shows state=0, tx_start=0, busy=0, tx_data=0. After release, a new arm starts a clean frame beginning with A5.
- Byte stability: monitor checks tx_data never changes within a slot, and that tx_start is high exactly once per slot, in its first cycle.
